// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the fetch FSM state encoding and the reset/NOP defaults.
package if_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } fetch_state_t;

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch: PC register, single-outstanding imem request FSM
// and a one-entry output buffer handing instructions to decode.
module if_fetch
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [XLEN-1:0] i_pc_next,
    input  logic            i_redirect,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_four,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [XLEN-1:0] i_imem_rdata,
    output logic [XLEN-1:0] o_instr,
    output logic [XLEN-1:0] o_instr_pc,
    output logic            o_instr_vld,
    input  logic            i_instr_rdy,
    output logic            o_fetch_err
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] ipc_q, ipc_d;
    logic            err_q, err_d;
    logic            misaligned;

    assign misaligned = |pc_q[1:0];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            ipc_q   <= RESET_PC;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        ipc_d      = ipc_q;
        err_d      = err_q;
        o_imem_req = 1'b0;
        unique case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (misaligned) begin
                    instr_d = NOP_INSTR;
                    ipc_d   = pc_q;
                    err_d   = 1'b1;
                    state_d = S_HOLD;
                end else begin
                    o_imem_req = 1'b1;
                    if (i_redirect) pc_d = i_pc_next;
                    if (i_imem_gnt)
                        state_d = i_redirect ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_redirect) begin
                    pc_d    = i_pc_next;
                    state_d = i_imem_rvalid ? S_REQ : S_DRAIN;
                end else if (i_imem_rvalid) begin
                    instr_d = i_imem_rdata;
                    ipc_d   = pc_q;
                    err_d   = 1'b0;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                // redirect drops the held word; rdy retires it
                if (i_redirect || i_instr_rdy) begin
                    pc_d    = i_pc_next;
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                if (i_redirect) pc_d = i_pc_next;
                if (i_imem_rvalid) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_pc        = pc_q;
    assign o_pc_four   = pc_q + 32'd4;
    assign o_imem_addr = pc_q;
    assign o_instr     = instr_q;
    assign o_instr_pc  = ipc_q;
    assign o_fetch_err = err_q;
    assign o_instr_vld = (state_q == S_HOLD);

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: boot, back-pressure, redirects,
// misaligned fetch, PC wrap and reset from the hold state.
module tb_if_fetch;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic [31:0] i_pc_next;
    logic        i_redirect = 1'b0;
    logic [31:0] o_pc, o_pc_four, o_imem_addr;
    logic        o_imem_req;
    logic        i_imem_gnt = 1'b0;
    logic        i_imem_rvalid = 1'b0;
    logic [31:0] i_imem_rdata = 32'h0;
    logic [31:0] o_instr, o_instr_pc;
    logic        o_instr_vld, o_fetch_err;
    logic        i_instr_rdy = 1'b0;
    logic [31:0] tgt = 32'h0;

    int n_chk = 0;
    int n_fail = 0;

    // PC-select mux: sequential unless redirecting
    assign i_pc_next = i_redirect ? tgt : o_pc_four;

    always #5 i_clk = ~i_clk;

    if_fetch dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_pc_next    (i_pc_next),
        .i_redirect   (i_redirect),
        .o_pc         (o_pc),
        .o_pc_four    (o_pc_four),
        .o_imem_req   (o_imem_req),
        .o_imem_addr  (o_imem_addr),
        .i_imem_gnt   (i_imem_gnt),
        .i_imem_rvalid(i_imem_rvalid),
        .i_imem_rdata (i_imem_rdata),
        .o_instr      (o_instr),
        .o_instr_pc   (o_instr_pc),
        .o_instr_vld  (o_instr_vld),
        .i_instr_rdy  (i_instr_rdy),
        .o_fetch_err  (o_fetch_err)
    );

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        chk("rst_pc", o_pc, 32'h0);
        chk("rst_req", {31'b0, o_imem_req}, 32'h0);
        chk("rst_vld", {31'b0, o_instr_vld}, 32'h0);
        chk("rst_err", {31'b0, o_fetch_err}, 32'h0);
        chk("rst_instr", o_instr, 32'h0000_0013);
        chk("rst_ipc", o_instr_pc, 32'h0);
        step();
        chk("boot_req", {31'b0, o_imem_req}, 32'h1);
        chk("boot_addr", o_imem_addr, 32'h0);
        i_imem_gnt = 1'b1;
        step();
        i_imem_gnt = 1'b0;
        chk("wait_req", {31'b0, o_imem_req}, 32'h0);
        chk("wait_vld", {31'b0, o_instr_vld}, 32'h0);
        i_imem_rvalid = 1'b1;
        i_imem_rdata = 32'hAAAA_0001;
        step();
        i_imem_rvalid = 1'b0;
        chk("first_vld", {31'b0, o_instr_vld}, 32'h1);
        chk("first_instr", o_instr, 32'hAAAA_0001);
        chk("first_ipc", o_instr_pc, 32'h0);
        chk("first_err", {31'b0, o_fetch_err}, 32'h0);
        i_instr_rdy = 1'b1;
        step();
        i_instr_rdy = 1'b0;
        chk("seq_req", {31'b0, o_imem_req}, 32'h1);
        chk("seq_addr", o_imem_addr, 32'h4);
    endtask

    task automatic fetch_one(input logic [31:0] data);
        i_imem_gnt = 1'b1;
        step();
        i_imem_gnt = 1'b0;
        i_imem_rvalid = 1'b1;
        i_imem_rdata = data;
        step();
        i_imem_rvalid = 1'b0;
    endtask

    task automatic test_backpressure();
        fetch_one(32'hBBBB_0002);
        for (int i = 0; i < 5; i++) begin
            chk("bp_vld", {31'b0, o_instr_vld}, 32'h1);
            chk("bp_instr", o_instr, 32'hBBBB_0002);
            chk("bp_ipc", o_instr_pc, 32'h4);
            chk("bp_req", {31'b0, o_imem_req}, 32'h0);
            step();
        end
        i_instr_rdy = 1'b1;
        step();
        i_instr_rdy = 1'b0;
        chk("bp_next_addr", o_imem_addr, 32'h8);
        chk("bp_next_req", {31'b0, o_imem_req}, 32'h1);
    endtask

    task automatic test_redirect_wait();
        i_imem_gnt = 1'b1;
        step();
        i_imem_gnt = 1'b0;
        i_redirect = 1'b1;
        tgt = 32'h100;
        step();
        i_redirect = 1'b0;
        chk("rw_pc", o_pc, 32'h100);
        chk("rw_req", {31'b0, o_imem_req}, 32'h0);
        step();
        chk("rw_drain_req", {31'b0, o_imem_req}, 32'h0);
        chk("rw_drain_vld", {31'b0, o_instr_vld}, 32'h0);
        i_imem_rvalid = 1'b1;
        i_imem_rdata = 32'hDEAD_BEEF;
        step();
        i_imem_rvalid = 1'b0;
        chk("rw_vld", {31'b0, o_instr_vld}, 32'h0);
        chk("rw_req2", {31'b0, o_imem_req}, 32'h1);
        chk("rw_addr", o_imem_addr, 32'h100);
        fetch_one(32'hCCCC_0003);
        chk("rw_instr", o_instr, 32'hCCCC_0003);
        chk("rw_ipc", o_instr_pc, 32'h100);
        i_instr_rdy = 1'b1;
        step();
        i_instr_rdy = 1'b0;
        chk("rw_seq", o_imem_addr, 32'h104);
    endtask

    task automatic test_redirect_gnt();
        i_imem_gnt = 1'b1;
        i_redirect = 1'b1;
        tgt = 32'h200;
        step();
        i_imem_gnt = 1'b0;
        i_redirect = 1'b0;
        chk("rg_pc", o_pc, 32'h200);
        chk("rg_req", {31'b0, o_imem_req}, 32'h0);
        i_imem_rvalid = 1'b1;
        i_imem_rdata = 32'hBAD0_BAD0;
        step();
        i_imem_rvalid = 1'b0;
        chk("rg_vld", {31'b0, o_instr_vld}, 32'h0);
        chk("rg_addr", o_imem_addr, 32'h200);
        chk("rg_req2", {31'b0, o_imem_req}, 32'h1);
        fetch_one(32'hDDDD_0004);
        chk("rg_instr", o_instr, 32'hDDDD_0004);
        chk("rg_ipc", o_instr_pc, 32'h200);
    endtask

    task automatic test_misaligned_wrap();
        i_redirect = 1'b1;
        tgt = 32'h102;
        step();
        i_redirect = 1'b0;
        chk("ma_pc", o_pc, 32'h102);
        chk("ma_req", {31'b0, o_imem_req}, 32'h0);
        step();
        chk("ma_req2", {31'b0, o_imem_req}, 32'h0);
        chk("ma_vld", {31'b0, o_instr_vld}, 32'h1);
        chk("ma_err", {31'b0, o_fetch_err}, 32'h1);
        chk("ma_instr", o_instr, 32'h0000_0013);
        chk("ma_ipc", o_instr_pc, 32'h102);
        i_redirect = 1'b1;
        tgt = 32'hFFFF_FFFC;
        step();
        i_redirect = 1'b0;
        chk("wr_pc", o_pc, 32'hFFFF_FFFC);
        chk("wr_four", o_pc_four, 32'h0);
        chk("wr_addr", o_imem_addr, 32'hFFFF_FFFC);
        fetch_one(32'hEEEE_0005);
        chk("wr_ipc", o_instr_pc, 32'hFFFF_FFFC);
        chk("wr_err", {31'b0, o_fetch_err}, 32'h0);
        chk("wr_vld", {31'b0, o_instr_vld}, 32'h1);
    endtask

    task automatic test_reset_hold();
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        chk("rh_vld", {31'b0, o_instr_vld}, 32'h0);
        chk("rh_pc", o_pc, 32'h0);
        chk("rh_req", {31'b0, o_imem_req}, 32'h0);
        chk("rh_instr", o_instr, 32'h0000_0013);
        chk("rh_ipc", o_instr_pc, 32'h0);
    endtask

    initial begin
        step();
        test_reset();
        test_backpressure();
        test_redirect_wait();
        test_redirect_gnt();
        test_misaligned_wrap();
        test_reset_hold();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
